// File: rtl/hci_package.sv
// Shared HCI widths and defaults.
// Imported by the ordered mux and its source FIFO.
package hci_package;

   localparam int DEFAULT_AW = 32;
   localparam int DEFAULT_DW = 32;
   localparam int DEFAULT_BW = 8;
   localparam int DEFAULT_UW = 1;
   localparam int DEFAULT_MUX_OUTSTANDING = 4;

   localparam logic SRC_IN0 = 1'b0;
   localparam logic SRC_IN1 = 1'b1;

endpackage

// File: rtl/hci_core_intf.sv
// HCI core request/response bundle.
// Master drives requests, slave drives grant and responses.
interface hci_core_intf #(
   parameter int AW = hci_package::DEFAULT_AW,
   parameter int DW = hci_package::DEFAULT_DW,
   parameter int BW = hci_package::DEFAULT_BW,
   parameter int UW = hci_package::DEFAULT_UW
) ();

   logic          req;
   logic          gnt;
   logic [AW-1:0] add;
   logic          wen;
   logic [DW-1:0] data;
   logic [DW/BW-1:0] be;
   logic [15:0]   boffs;
   logic [UW-1:0] user;
   logic          lrdy;
   logic [DW-1:0] r_data;
   logic          r_valid;
   logic          r_opc;
   logic [UW-1:0] r_user;

   modport master (
      output req, add, wen, data, be, boffs, user, lrdy,
      input  gnt, r_data, r_valid, r_opc, r_user
   );

   modport slave (
      input  req, add, wen, data, be, boffs, user, lrdy,
      output gnt, r_data, r_valid, r_opc, r_user
   );

endinterface

// File: rtl/hci_core_mux_srcfifo.sv
// One-bit source FIFO recording which initiator owns each
// outstanding request, in grant order.
module hci_core_mux_srcfifo
   import hci_package::*;
#(
   parameter int DEPTH = DEFAULT_MUX_OUTSTANDING
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic full,
   output logic empty,
   output logic head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign head    = mem[rptr];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem   <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (clear_i) begin
         mem   <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            mem[wptr] <= din;
            wptr      <= wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= rptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hci_core_ordered_mux.sv
// Two-to-one HCI mux with fair arbitration and in-order
// response routing back to the owning initiator.
module hci_core_ordered_mux
   import hci_package::*;
#(
   parameter int AW = DEFAULT_AW,
   parameter int DW = DEFAULT_DW,
   parameter int MAX_OUTSTANDING = DEFAULT_MUX_OUTSTANDING
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clear_i,
   hci_core_intf.slave  in0,
   hci_core_intf.slave  in1,
   hci_core_intf.master out,
   output logic         err_o
);

   logic          last_q;
   logic          sel_q;
   logic          sel;
   logic          any_req;
   logic          out_req;
   logic          hs;
   logic          pop;
   logic          full;
   logic          empty;
   logic          head;
   logic          rsp0;
   logic          rsp1;
   logic [AW-1:0] add_mux;
   logic [DW-1:0] data_mux;

   // With no request pending the previous selection is held.
   always_comb begin
      sel = sel_q;
      unique case (1'b1)
         (in0.req & in1.req):  sel = ~last_q;
         (in0.req & ~in1.req): sel = SRC_IN0;
         (~in0.req & in1.req): sel = SRC_IN1;
         default:              sel = sel_q;
      endcase
   end

   assign any_req = in0.req | in1.req;
   assign out_req = rst_ni & any_req & ~full;
   assign hs      = out_req & out.gnt;
   assign pop     = out.r_valid & ~empty;

   assign add_mux  = sel ? in1.add  : in0.add;
   assign data_mux = sel ? in1.data : in0.data;

   assign out.req   = out_req;
   assign out.add   = add_mux;
   assign out.data  = data_mux;
   assign out.wen   = sel ? in1.wen   : in0.wen;
   assign out.be    = sel ? in1.be    : in0.be;
   assign out.boffs = sel ? in1.boffs : in0.boffs;
   assign out.lrdy  = sel ? in1.lrdy  : in0.lrdy;
   assign out.user  = sel ? in1.user  : in0.user;

   assign in0.gnt = out.gnt & out_req & (sel == SRC_IN0);
   assign in1.gnt = out.gnt & out_req & (sel == SRC_IN1);

   // Responses go to the FIFO head; an empty FIFO routes nowhere.
   assign rsp0 = rst_ni & ~empty & (head == SRC_IN0);
   assign rsp1 = rst_ni & ~empty & (head == SRC_IN1);

   assign in0.r_valid = out.r_valid & rsp0;
   assign in0.r_data  = rsp0 ? out.r_data : '0;
   assign in0.r_opc   = rsp0 ? out.r_opc  : 1'b0;
   assign in0.r_user  = rsp0 ? out.r_user : '0;

   assign in1.r_valid = out.r_valid & rsp1;
   assign in1.r_data  = rsp1 ? out.r_data : '0;
   assign in1.r_opc   = rsp1 ? out.r_opc  : 1'b0;
   assign in1.r_user  = rsp1 ? out.r_user : '0;

   hci_core_mux_srcfifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) i_srcfifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (clear_i),
      .push    (hs),
      .din     (sel),
      .pop     (pop),
      .full    (full),
      .empty   (empty),
      .head    (head)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_q <= SRC_IN1;
         sel_q  <= SRC_IN0;
         err_o  <= 1'b0;
      end else if (clear_i) begin
         last_q <= SRC_IN1;
         sel_q  <= SRC_IN0;
         err_o  <= 1'b0;
      end else begin
         sel_q <= sel;
         if (hs) begin
            last_q <= sel;
         end
         if (out.r_valid & empty) begin
            err_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hci_core_ordered_mux.sv
// Directed bench for hci_core_ordered_mux: arbitration,
// backpressure, response ordering, error flag and reset.
module tb_hci_core_ordered_mux;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic clear = 1'b0;
   logic err;
   int   checks = 0;
   int   errors = 0;

   hci_core_intf #(.AW(32), .DW(32)) if0 ();
   hci_core_intf #(.AW(32), .DW(32)) if1 ();
   hci_core_intf #(.AW(32), .DW(32)) ifo ();

   hci_core_ordered_mux #(
      .AW (32),
      .DW (32),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .clear_i (clear),
      .in0     (if0),
      .in1     (if1),
      .out     (ifo),
      .err_o   (err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      if0.req = 0; if0.add = 32'h0; if0.wen = 1; if0.data = 0;
      if0.be = '1; if0.boffs = 0; if0.user = 0; if0.lrdy = 1;
      if1.req = 0; if1.add = 32'h4; if1.wen = 1; if1.data = 0;
      if1.be = '1; if1.boffs = 0; if1.user = 0; if1.lrdy = 1;
      ifo.gnt = 1; ifo.r_valid = 0; ifo.r_data = 0;
      ifo.r_opc = 0; ifo.r_user = 0;
      clear = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      rst_ni = 0;
      if0.req = 1; if1.req = 1; ifo.r_valid = 1;
      #3;
      checks++;
      if (ifo.req !== 1'b0) begin errors++;
         $display("FAIL rst_out_req got %b want 0", ifo.req); end
      checks++;
      if (if0.gnt !== 1'b0) begin errors++;
         $display("FAIL rst_gnt0 got %b want 0", if0.gnt); end
      checks++;
      if (if1.gnt !== 1'b0) begin errors++;
         $display("FAIL rst_gnt1 got %b want 0", if1.gnt); end
      checks++;
      if (if0.r_valid !== 1'b0) begin errors++;
         $display("FAIL rst_rv0 got %b want 0", if0.r_valid); end
      checks++;
      if (if1.r_valid !== 1'b0) begin errors++;
         $display("FAIL rst_rv1 got %b want 0", if1.r_valid); end
      checks++;
      if (err !== 1'b0) begin errors++;
         $display("FAIL rst_err got %b want 0", err); end
      step(); idle();
      step(); rst_ni = 1;
   endtask

   task automatic test_round_robin();
      logic e0;
      for (int k = 0; k < 4; k++) begin
         step(); idle();
         if0.req = 1; if1.req = 1;
         #1;
         e0 = (k % 2 == 0);
         checks++;
         if (if0.gnt !== e0) begin errors++;
            $display("FAIL rr_gnt0[%0d] got %b want %b", k, if0.gnt, e0); end
         checks++;
         if (if1.gnt !== !e0) begin errors++;
            $display("FAIL rr_gnt1[%0d] got %b want %b", k, if1.gnt, !e0); end
      end
      for (int k = 0; k < 4; k++) begin
         step(); idle();
         ifo.r_valid = 1;
         ifo.r_data = 32'h100 + k;
         #1;
         e0 = (k % 2 == 0);
         checks++;
         if (if0.r_valid !== e0) begin errors++;
            $display("FAIL rr_rv0[%0d] got %b want %b", k, if0.r_valid, e0); end
         checks++;
         if (if1.r_valid !== !e0) begin errors++;
            $display("FAIL rr_rv1[%0d] got %b want %b", k, if1.r_valid, !e0); end
      end
      step(); idle(); #1;
      checks++;
      if (err !== 1'b0) begin errors++;
         $display("FAIL rr_err got %b want 0", err); end
   endtask

   task automatic test_single_read();
      step(); idle();
      if1.req = 1; if1.wen = 1; if1.add = 32'h0000_0100;
      #1;
      checks++;
      if (if1.gnt !== 1'b1) begin errors++;
         $display("FAIL rd_gnt1 got %b want 1", if1.gnt); end
      checks++;
      if (if0.gnt !== 1'b0) begin errors++;
         $display("FAIL rd_gnt0 got %b want 0", if0.gnt); end
      checks++;
      if (ifo.add !== 32'h0000_0100) begin errors++;
         $display("FAIL rd_add got %h want 00000100", ifo.add); end
      step(); idle();
      step(); idle();
      ifo.r_valid = 1; ifo.r_data = 32'h1234_5678;
      #1;
      checks++;
      if (if1.r_valid !== 1'b1) begin errors++;
         $display("FAIL rd_rv1 got %b want 1", if1.r_valid); end
      checks++;
      if (if1.r_data !== 32'h1234_5678) begin errors++;
         $display("FAIL rd_data1 got %h want 12345678", if1.r_data); end
      checks++;
      if (if0.r_valid !== 1'b0) begin errors++;
         $display("FAIL rd_rv0 got %b want 0", if0.r_valid); end
      checks++;
      if (if0.r_data !== 32'h0) begin errors++;
         $display("FAIL rd_data0 got %h want 0", if0.r_data); end
      step(); idle();
   endtask

   task automatic test_full();
      for (int k = 0; k < 4; k++) begin
         step(); idle(); if0.req = 1; #1;
         checks++;
         if (if0.gnt !== 1'b1) begin errors++;
            $display("FAIL full_fill[%0d] got %b want 1", k, if0.gnt); end
      end
      for (int k = 0; k < 2; k++) begin
         step(); idle(); if0.req = 1; #1;
         checks++;
         if (ifo.req !== 1'b0) begin errors++;
            $display("FAIL full_req[%0d] got %b want 0", k, ifo.req); end
         checks++;
         if (if0.gnt !== 1'b0) begin errors++;
            $display("FAIL full_gnt[%0d] got %b want 0", k, if0.gnt); end
      end
      step(); idle(); if0.req = 1; ifo.r_valid = 1; #1;
      checks++;
      if (ifo.req !== 1'b0) begin errors++;
         $display("FAIL full_pop_req got %b want 0", ifo.req); end
      checks++;
      if (if0.gnt !== 1'b0) begin errors++;
         $display("FAIL full_pop_gnt got %b want 0", if0.gnt); end
      checks++;
      if (if0.r_valid !== 1'b1) begin errors++;
         $display("FAIL full_pop_rv got %b want 1", if0.r_valid); end
      step(); idle(); if0.req = 1; #1;
      checks++;
      if (ifo.req !== 1'b1) begin errors++;
         $display("FAIL full_rearm_req got %b want 1", ifo.req); end
      checks++;
      if (if0.gnt !== 1'b1) begin errors++;
         $display("FAIL full_rearm_gnt got %b want 1", if0.gnt); end
      for (int k = 0; k < 4; k++) begin
         step(); idle(); ifo.r_valid = 1; #1;
         checks++;
         if (if0.r_valid !== 1'b1) begin errors++;
            $display("FAIL full_drain[%0d] got %b want 1", k, if0.r_valid); end
      end
      step(); idle(); #1;
      checks++;
      if (err !== 1'b0) begin errors++;
         $display("FAIL full_err got %b want 0", err); end
   endtask

   task automatic test_order();
      logic [31:0] rd [3];
      logic        own [3];
      rd[0] = 32'hAAAA_0001; rd[1] = 32'hBBBB_0002; rd[2] = 32'hCCCC_0003;
      own[0] = 0; own[1] = 1; own[2] = 0;
      for (int k = 0; k < 3; k++) begin
         step(); idle();
         if (own[k]) if1.req = 1; else if0.req = 1;
         #1;
         checks++;
         if ({if1.gnt, if0.gnt} !== (own[k] ? 2'b10 : 2'b01)) begin errors++;
            $display("FAIL ord_gnt[%0d] got %b%b want owner %0d",
                     k, if1.gnt, if0.gnt, own[k]); end
      end
      for (int k = 0; k < 3; k++) begin
         step(); idle();
         ifo.r_valid = 1; ifo.r_data = rd[k];
         #1;
         checks++;
         if (if0.r_valid !== !own[k]) begin errors++;
            $display("FAIL ord_rv0[%0d] got %b want %b", k, if0.r_valid, !own[k]); end
         checks++;
         if (if1.r_valid !== own[k]) begin errors++;
            $display("FAIL ord_rv1[%0d] got %b want %b", k, if1.r_valid, own[k]); end
         checks++;
         if ((own[k] ? if1.r_data : if0.r_data) !== rd[k]) begin errors++;
            $display("FAIL ord_data[%0d] got %h/%h want %h",
                     k, if0.r_data, if1.r_data, rd[k]); end
      end
      step(); idle();
   endtask

   task automatic test_unexpected();
      step(); idle(); ifo.r_valid = 1; ifo.r_data = 32'hDEAD_BEEF; #1;
      checks++;
      if (if0.r_valid !== 1'b0) begin errors++;
         $display("FAIL unx_rv0 got %b want 0", if0.r_valid); end
      checks++;
      if (if1.r_valid !== 1'b0) begin errors++;
         $display("FAIL unx_rv1 got %b want 0", if1.r_valid); end
      step(); idle(); #1;
      checks++;
      if (err !== 1'b1) begin errors++;
         $display("FAIL unx_err_set got %b want 1", err); end
      step(); idle(); #1;
      checks++;
      if (err !== 1'b1) begin errors++;
         $display("FAIL unx_err_hold got %b want 1", err); end
      step(); idle(); clear = 1; #1;
      checks++;
      if (err !== 1'b1) begin errors++;
         $display("FAIL unx_err_clr_cyc got %b want 1", err); end
      step(); idle(); #1;
      checks++;
      if (err !== 1'b0) begin errors++;
         $display("FAIL unx_err_cleared got %b want 0", err); end
   endtask

   task automatic test_reset_outstanding();
      step(); idle(); if1.req = 1; #1;
      checks++;
      if (if1.gnt !== 1'b1) begin errors++;
         $display("FAIL ro_gnt1 got %b want 1", if1.gnt); end
      step(); idle(); if0.req = 1; #1;
      checks++;
      if (if0.gnt !== 1'b1) begin errors++;
         $display("FAIL ro_gnt0 got %b want 1", if0.gnt); end
      step(); idle(); rst_ni = 0;
      step(); step(); rst_ni = 1;
      step(); idle(); ifo.r_valid = 1; #1;
      checks++;
      if ({if1.r_valid, if0.r_valid} !== 2'b00) begin errors++;
         $display("FAIL ro_empty_rv got %b%b want 00", if1.r_valid, if0.r_valid); end
      step(); idle(); if0.req = 1; if1.req = 1; #1;
      checks++;
      if (err !== 1'b1) begin errors++;
         $display("FAIL ro_err got %b want 1", err); end
      checks++;
      if (if0.gnt !== 1'b1) begin errors++;
         $display("FAIL ro_tie_gnt0 got %b want 1", if0.gnt); end
      checks++;
      if (if1.gnt !== 1'b0) begin errors++;
         $display("FAIL ro_tie_gnt1 got %b want 0", if1.gnt); end
      step(); idle(); ifo.r_valid = 1; ifo.r_data = 32'h0BAD_F00D; #1;
      checks++;
      if (if0.r_data !== 32'h0BAD_F00D || if0.r_valid !== 1'b1) begin errors++;
         $display("FAIL ro_rsp0 got %b/%h want 1/0badf00d", if0.r_valid, if0.r_data); end
      step(); idle(); clear = 1;
      step(); idle(); #1;
      checks++;
      if (err !== 1'b0) begin errors++;
         $display("FAIL ro_clr_err got %b want 0", err); end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_read();
      test_full();
      test_order();
      test_unexpected();
      test_reset_outstanding();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
